// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, operands
// loaded in parallel and summed LSB-first over WIDTH cycles.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Single-bit full adder slice: returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         slice_s;

  assign slice_s = full_adder(a_sr_q[0], b_sr_q[0], carry_q);

  // Next-state and datapath control; result registers move only on DONE entry.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = c_in;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {slice_s[0], sum_sr_q[WIDTH-1:1]};
        carry_d  = slice_s[1];
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB, so ovf = cin(MSB) ^ cout(MSB)
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_DONE;
          sum_d   = sum_sr_d;
          c_out_d = slice_s[1];
          ovf_d   = carry_q ^ slice_s[1];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= {WIDTH{1'b0}};
      b_sr_q   <= {WIDTH{1'b0}};
      sum_sr_q <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      sum_q    <= {WIDTH{1'b0}};
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and randomized self-checking bench for bit_serial_adder (WIDTH=8).
module tb_bit_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       c_out;
  logic       ovf;

  int pass_cnt;
  int total_cnt;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one add and wait (bounded) for done; caller sits 1 unit after an edge.
  task automatic run_add(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         output logic [7:0] s, output logic co, output logic ov,
                         output int busy_cycles, output int lat);
    a = av; b = bv; c_in = ci; start = 1'b1;
    step();
    start = 1'b0;
    a = 8'hXX; b = 8'hXX; c_in = 1'bx;
    busy_cycles = 0;
    lat = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      step();
      lat++;
    end
    a = 8'h00; b = 8'h00; c_in = 1'b0;
    s = sum; co = c_out; ov = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({busy, done, sum, c_out, ovf} !== 12'h000)
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h c_out=%b ovf=%b, want all 0",
               busy, done, sum, c_out, ovf);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] s; logic co, ov; int bc, lat;
    run_add(8'h0F, 8'h01, 1'b0, s, co, ov, bc, lat);
    total_cnt++;
    if (lat !== 8) $display("FAIL basic_latency: got %0d, want 8", lat); else pass_cnt++;
    total_cnt++;
    if (bc !== 8) $display("FAIL basic_busy_cycles: got %0d, want 8", bc); else pass_cnt++;
    total_cnt++;
    if ({s, co, ov} !== {8'h10, 1'b0, 1'b0})
      $display("FAIL basic_result: got sum=%h c_out=%b ovf=%b, want 10/0/0", s, co, ov);
    else pass_cnt++;
    step();
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h10)
      $display("FAIL basic_hold: got done=%b busy=%b sum=%h, want 0/0/10", done, busy, sum);
    else pass_cnt++;
  endtask

  task automatic test_carry_ovf();
    logic [7:0] s; logic co, ov; int bc, lat;
    run_add(8'hFF, 8'h00, 1'b1, s, co, ov, bc, lat);
    total_cnt++;
    if ({s, co, ov} !== {8'h00, 1'b1, 1'b0})
      $display("FAIL carry_wrap: got sum=%h c_out=%b ovf=%b, want 00/1/0", s, co, ov);
    else pass_cnt++;
    step();
    run_add(8'h7F, 8'h01, 1'b0, s, co, ov, bc, lat);
    total_cnt++;
    if ({s, co, ov} !== {8'h80, 1'b0, 1'b1})
      $display("FAIL signed_ovf: got sum=%h c_out=%b ovf=%b, want 80/0/1", s, co, ov);
    else pass_cnt++;
    step();
  endtask

  task automatic test_start_ignored();
    int dones; int done_at;
    a = 8'h33; b = 8'h11; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    dones = 0; done_at = -1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin a = 8'hAA; b = 8'h55; c_in = 1'b1; start = 1'b1; end
      if (i == 4) begin start = 1'b0; end
      if (done) begin
        dones++;
        if (done_at < 0) done_at = i;
        total_cnt++;
        if ({sum, c_out, ovf} !== {8'h44, 1'b0, 1'b0})
          $display("FAIL ignore_result: got sum=%h c_out=%b ovf=%b, want 44/0/0", sum, c_out, ovf);
        else pass_cnt++;
      end
      step();
    end
    total_cnt++;
    if (dones !== 1) $display("FAIL ignore_done_count: got %0d, want 1", dones); else pass_cnt++;
    total_cnt++;
    if (done_at !== 8) $display("FAIL ignore_latency: got %0d, want 8", done_at); else pass_cnt++;
    a = 8'h00; b = 8'h00; c_in = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s; logic co, ov; int bc, lat; int dones;
    a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, sum, c_out, ovf} !== 12'h000)
      $display("FAIL midrun_reset: got busy=%b done=%b sum=%h c_out=%b ovf=%b, want all 0",
               busy, done, sum, c_out, ovf);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dones++;
      step();
    end
    total_cnt++;
    if (dones !== 0) $display("FAIL midrun_no_done: got %0d active cycles, want 0", dones);
    else pass_cnt++;
    run_add(8'h01, 8'h02, 1'b0, s, co, ov, bc, lat);
    total_cnt++;
    if ({s, co, ov} !== {8'h03, 1'b0, 1'b0})
      $display("FAIL midrun_recover: got sum=%h c_out=%b ovf=%b, want 03/0/0", s, co, ov);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    int t; int t1; int t2;
    a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
    step();
    a = 8'h01; b = 8'h01;
    t = 0; t1 = -1; t2 = -1;
    while (t < 40 && t2 < 0) begin
      if (done) begin
        if (t1 < 0) begin
          t1 = t;
          total_cnt++;
          if ({sum, c_out, ovf} !== {8'h00, 1'b1, 1'b1})
            $display("FAIL b2b_first: got sum=%h c_out=%b ovf=%b, want 00/1/1", sum, c_out, ovf);
          else pass_cnt++;
        end else begin
          t2 = t;
          start = 1'b0;
          total_cnt++;
          if ({sum, c_out, ovf} !== {8'h02, 1'b0, 1'b0})
            $display("FAIL b2b_second: got sum=%h c_out=%b ovf=%b, want 02/0/0", sum, c_out, ovf);
          else pass_cnt++;
        end
      end
      step();
      t++;
    end
    start = 1'b0;
    total_cnt++;
    if (t2 - t1 !== 9 || t1 < 0)
      $display("FAIL b2b_spacing: got first=%0d second=%0d, want spacing 9", t1, t2);
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL b2b_idle: got busy=%b done=%b, want 0/0", busy, done);
    else pass_cnt++;
    a = 8'h00; b = 8'h00;
  endtask

  task automatic test_random();
    logic [7:0] s; logic co, ov; int bc, lat;
    logic [7:0] av, bv; logic ci; logic [8:0] ref_sum; logic ref_ovf;
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      ci = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, av} + {1'b0, bv} + {8'h00, ci};
      ref_ovf = (av[7] == bv[7]) && (ref_sum[7] != av[7]);
      run_add(av, bv, ci, s, co, ov, bc, lat);
      total_cnt++;
      if ({co, s, ov} !== {ref_sum, ref_ovf} || lat !== 8)
        $display("FAIL random_%0d: a=%h b=%h cin=%b got c_out=%b sum=%h ovf=%b lat=%0d, want %b %h %b 8",
                 i, av, bv, ci, co, s, ov, lat, ref_sum[8], ref_sum[7:0], ref_ovf);
      else pass_cnt++;
      if (i % 2 == 0) step();
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_carry_ovf();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
